// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 gamepad front end: key codes, button indices,
// receiver state encoding and small lookup/parity helpers.
package ps2_pkg;

    localparam logic [7:0] PS2_E0    = 8'hE0;
    localparam logic [7:0] PS2_F0    = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_X     = 8'h22;
    localparam logic [7:0] KEY_Z     = 8'h1A;

    localparam logic [2:0] BTN_A      = 3'd7;
    localparam logic [2:0] BTN_B      = 3'd6;
    localparam logic [2:0] BTN_SELECT = 3'd5;
    localparam logic [2:0] BTN_START  = 3'd4;
    localparam logic [2:0] BTN_UP     = 3'd3;
    localparam logic [2:0] BTN_DOWN   = 3'd2;
    localparam logic [2:0] BTN_LEFT   = 3'd1;
    localparam logic [2:0] BTN_RIGHT  = 3'd0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    // Map {extended, code} onto an inreg bit; keypad codes without E0 miss.
    function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 3'd0;
        case ({ext, code})
            {1'b1, KEY_UP}:    r.idx = BTN_UP;
            {1'b1, KEY_DOWN}:  r.idx = BTN_DOWN;
            {1'b1, KEY_LEFT}:  r.idx = BTN_LEFT;
            {1'b1, KEY_RIGHT}: r.idx = BTN_RIGHT;
            {1'b0, KEY_ENTER}: r.idx = BTN_START;
            {1'b0, KEY_SPACE}: r.idx = BTN_SELECT;
            {1'b0, KEY_X}:     r.idx = BTN_A;
            {1'b0, KEY_Z}:     r.idx = BTN_B;
            default:           r.hit = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter,
// frame FSM with odd-parity/stop checking and an inter-edge timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER     = 4
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam longint TMO_CYC   = longint'(CLK_HZ) * longint'(TIMEOUT_US) / 64'd1000000;
    localparam logic [31:0] TMO_LOAD = 32'(TMO_CYC - 64'd1);
    localparam int FW = $clog2(FILTER + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);

    logic          clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
    logic          filt_r;
    logic [FW-1:0] filt_cnt_r;
    logic          fall_s;
    rx_state_t     state_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [31:0]   tmo_r;

    // Two-flop synchronisers, idle level 1
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Filtered clock follows the pin only after FILTER consecutive differing samples
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            filt_r     <= 1'b1;
            filt_cnt_r <= '0;
        end else if (clk_sync_r == filt_r) begin
            filt_cnt_r <= '0;
        end else if (filt_cnt_r == FILT_LAST) begin
            filt_r     <= clk_sync_r;
            filt_cnt_r <= '0;
        end else begin
            filt_cnt_r <= filt_cnt_r + 1'b1;
        end
    end

    // The cycle in which the filtered clock commits a 1->0 change
    assign fall_s = filt_r & ~clk_sync_r & (filt_cnt_r == FILT_LAST);

    // Frame FSM; timeout only matters while a frame is in progress
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_r      <= 1'b0;
            tmo_r      <= TMO_LOAD;
            scan_valid <= 1'b0;
            scan_code  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_s) begin
                tmo_r <= TMO_LOAD;
                case (state_r)
                    IDLE: begin
                        if (!dat_sync_r) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_r   <= {dat_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_r   <= dat_sync_r;
                        state_r <= STOP;
                    end
                    STOP: begin
                        if (dat_sync_r && odd_parity_ok(shift_r, par_r)) begin
                            scan_valid <= 1'b1;
                            scan_code  <= shift_r;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state_r <= IDLE;
                    end
                    default: state_r <= IDLE;
                endcase
            end else if (state_r == IDLE) begin
                tmo_r <= TMO_LOAD;
            end else if (tmo_r == 32'd0) begin
                frame_err <= 1'b1;
                state_r   <= IDLE;
                bit_cnt_r <= 3'd0;
                tmo_r     <= TMO_LOAD;
            end else begin
                tmo_r <= tmo_r - 32'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_gamepad.sv
// PS/2 keyboard to Gigatron controller adapter: tracks E0/F0 prefixes and
// maps a fixed key set onto the active-low inreg bits.
module ps2_gamepad
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER     = 4
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] inreg,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic     ext_r, brk_r;
    key_hit_t hit_s;

    ps2_rx #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_US(TIMEOUT_US),
        .FILTER    (FILTER)
    ) u_rx (
        .clock     (clock),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    assign hit_s = key_lookup(ext_r, scan_code);

    // Prefix flags survive bad frames; any non-prefix code consumes them
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            inreg <= 8'hFF;
            ext_r <= 1'b0;
            brk_r <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == PS2_E0) begin
                ext_r <= 1'b1;
            end else if (scan_code == PS2_F0) begin
                brk_r <= 1'b1;
            end else begin
                if (hit_s.hit) begin
                    inreg[hit_s.idx] <= brk_r;
                end
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_gamepad.sv
// Self-checking bench for ps2_gamepad: frame-level reference model plus
// directed and randomized PS/2 traffic at a scaled-down clock rate.
module tb_ps2_gamepad;
    import ps2_pkg::*;

    // Scaled timing keeps the run short: 1 MHz system clock, 200-cycle timeout.
    localparam int CLK_HZ     = 1000000;
    localparam int TIMEOUT_US = 200;
    localparam int FILTER     = 4;
    localparam int TMO        = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int H          = 10;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] inreg, scan_code;
    logic       scan_valid, frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;
    int dut_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model_inreg = 8'hFF;
    logic [7:0] held_code   = 8'h00;
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;

    logic [8:0] key_tbl [8] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A, 9'h029, 9'h022, 9'h01A};
    int         key_idx [8] = '{3, 2, 1, 0, 4, 5, 7, 6};
    logic [7:0] pool    [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h29, 8'h22, 8'h1A};

    always #5 clock = ~clock;

    ps2_gamepad #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .FILTER(FILTER)) u_dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .inreg     (inreg),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int key_bit(input bit ext, input logic [7:0] code);
        for (int i = 0; i < 8; i++)
            if ({ext, code} == key_tbl[i]) return key_idx[i];
        return -1;
    endfunction

    task automatic model_decode(input logic [7:0] c);
        int b;
        if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_brk = 1'b1;
        else begin
            b = key_bit(m_ext, c);
            if (b >= 0) model_inreg[b] = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clock) begin
        logic [7:0] code;
        if (rst_n) begin
            check("inreg", inreg, model_inreg);
            check("valid_err_exclusive", scan_valid & frame_err, 0);
            if (frame_err) dut_err++;
            if (scan_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_scan_valid: got code %0h, expected no pulse", scan_code);
                end else begin
                    code = exp_q.pop_front();
                    check("scan_code", scan_code, code);
                    model_decode(code);
                    held_code = code;
                end
            end else begin
                check("scan_code_held", scan_code, held_code);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            tick(H / 2);
            ps2_clk = 1'b0;
            tick(1);
            ps2_clk = 1'b1;
            tick(H / 2 - 1);
        end else begin
            tick(H);
        end
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stop, (~^code) ^ bad_par, code, 1'b0};
        if (nbits == 11) begin
            if (!bad_par && stop) exp_q.push_back(code);
            else exp_err++;
        end
        for (int i = 0; i < nbits; i++) send_bit(f[i], glitch && (i % 3 == 1));
        ps2_dat = 1'b1;
        tick(3 * H);
    endtask

    task automatic good(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b1, 11, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_inreg = 8'hFF;
        held_code = 8'h00;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_q.delete();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(3);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        do_reset();
        check("reset_inreg", inreg, 8'hFF);
        check("reset_scan_valid", scan_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_scan_code", scan_code, 8'h00);
        rst_n = 1'b1;
        tick(5);

        good(8'h5A);
        check("enter_make_model", model_inreg, 8'hEF);
        check("enter_make", inreg, 8'hEF);
        good(8'hF0); good(8'h5A);
        check("enter_break", inreg, 8'hFF);

        good(8'hE0); good(8'h75); good(8'h22);
        check("up_and_a", inreg, 8'h77);
        good(8'hE0); good(8'hF0); good(8'h75);
        check("up_release", inreg, 8'h7F);
        good(8'h75);
        check("keypad_ignored", inreg, 8'h7F);
        good(8'h22);
        check("typematic", inreg, 8'h7F);

        send_frame(8'h1A, 1'b1, 1'b1, 11, 1'b0);
        check("bad_parity_inreg", inreg, 8'h7F);
        send_frame(8'h22, 1'b0, 1'b0, 11, 1'b0);
        ps2_dat = 1'b1;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
        exp_err++;
        tick(3 * H);
        check("error_count", dut_err, exp_err);

        good(8'hF0); good(8'h22);
        check("a_release", inreg, 8'hFF);
        send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
        tick(TMO + 50);
        exp_err++;
        check("timeout_err", dut_err, exp_err);
        check("timeout_idle", u_dut.u_rx.state_r, IDLE);
        good(8'h29);
        check("space_code", scan_code, 8'h29);
        check("space_make", inreg, 8'hDF);

        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b1);
        check("glitch_code", scan_code, 8'h5A);
        check("glitch_inreg", inreg, 8'hCF);

        good(8'hF0);
        send_frame(8'h1A, 1'b1, 1'b1, 11, 1'b0);
        good(8'h1A);
        check("flags_survive_err", inreg, 8'hCF);

        send_frame(8'h22, 1'b0, 1'b1, 4, 1'b0);
        do_reset();
        check("midframe_reset", inreg, 8'hFF);
        rst_n = 1'b1;
        tick(5);
        good(8'h22);
        check("after_reset", inreg, 8'h7F);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) c = 8'($urandom_range(255));
            else c = pool[$urandom_range(9)];
            send_frame(c, ($urandom_range(7) == 0), 1'b1, 11, 1'b0);
        end
        tick(5);
        check("final_err_count", dut_err, exp_err);
        check("final_pending", exp_q.size(), 0);
        check("final_inreg", inreg, model_inreg);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
